// File: rtl/motion_pkg.sv
// Shared types and constants for the motion sequencer.
//   state_e : sequencer states (IDLE, SLEW, SETTLE)
//   grant_e : which request source currently owns the servos
//   COORD_W : width of one coordinate axis
package motion_pkg;

  localparam int COORD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SLEW   = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_KB   = 2'b01,
    GRANT_US   = 2'b10
  } grant_e;

endpackage

// File: rtl/axis_slewer.sv
// One coordinate axis: holds the commanded position and moves it one unit
// toward the goal on each step strobe.
//   clk   : system clock
//   reset : asynchronous, active-high; position returns to HOME
//   step  : single-cycle strobe, move one unit toward goal
//   goal  : destination coordinate
//   pos   : current commanded coordinate
module axis_slewer
  import motion_pkg::*;
#(
  parameter int HOME = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic [COORD_W-1:0] goal,
  output logic [COORD_W-1:0] pos
);

  // Comparing before moving means pos never passes goal, so 0 and the
  // maximum coordinate are reached exactly and never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= COORD_W'(HOME);
    end else if (step) begin
      if (pos < goal) begin
        pos <= pos + 1'b1;
      end else if (pos > goal) begin
        pos <= pos - 1'b1;
      end
    end
  end

endmodule

// File: rtl/motion_sequencer.sv
// Arbitrates keyboard and ultrasonic move requests and slews the commanded
// coordinate toward the granted goal one unit per STEP_CYCLES, then keeps
// the servos enabled for SETTLE_CYCLES before releasing them.
//   clk, reset          : clock, asynchronous active-high reset
//   kb_req, kb_x, kb_y  : keyboard request (level) and goal coordinate
//   us_req, us_x, us_y  : ultrasonic request (level) and goal coordinate
//   target_x, target_y  : commanded coordinate to inverse kinematics
//   servo_en            : PWM enable, high outside IDLE
//   grant               : 00 none, 01 keyboard, 10 ultrasonic
//   busy                : high while slewing
//   at_target           : commanded coordinate equals latched goal
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int STEP_CYCLES   = 2_000_000,
  parameter int SETTLE_CYCLES = 50_000_000,
  parameter int HOME_X        = 2,
  parameter int HOME_Y        = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               kb_req,
  input  logic [COORD_W-1:0] kb_x,
  input  logic [COORD_W-1:0] kb_y,
  input  logic               us_req,
  input  logic [COORD_W-1:0] us_x,
  input  logic [COORD_W-1:0] us_y,
  output logic [COORD_W-1:0] target_x,
  output logic [COORD_W-1:0] target_y,
  output logic               servo_en,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               at_target
);

  localparam int STEP_W   = (STEP_CYCLES   > 1) ? $clog2(STEP_CYCLES)   : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e               state, state_n;
  grant_e               grant_q, grant_n;
  logic [COORD_W-1:0]   goal_x, goal_y, goal_x_n, goal_y_n;
  logic [STEP_W-1:0]    step_cnt;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic                 step_last, settle_last, step_stb, settle_clr;
  logic                 goal_n_reached;

  assign step_last   = (step_cnt   == STEP_W'(STEP_CYCLES - 1));
  assign settle_last = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
  assign step_stb    = (state == ST_SLEW) && step_last;

  assign goal_n_reached = (goal_x_n == target_x) && (goal_y_n == target_y);

  always_comb begin
    state_n    = state;
    grant_n    = grant_q;
    goal_x_n   = goal_x;
    goal_y_n   = goal_y;
    settle_clr = 1'b0;

    // The owning source steers the goal while it keeps requesting; once it
    // drops its request the last goal is kept so motion still completes.
    if (grant_q == GRANT_KB && kb_req) begin
      goal_x_n = kb_x;
      goal_y_n = kb_y;
    end else if (grant_q == GRANT_US && us_req) begin
      goal_x_n = us_x;
      goal_y_n = us_y;
    end

    case (state)
      ST_IDLE: begin
        if (kb_req) begin
          grant_n  = GRANT_KB;
          goal_x_n = kb_x;
          goal_y_n = kb_y;
        end else if (us_req) begin
          grant_n  = GRANT_US;
          goal_x_n = us_x;
          goal_y_n = us_y;
        end
        if (kb_req || us_req) begin
          state_n = goal_n_reached ? ST_SETTLE : ST_SLEW;
        end
      end

      ST_SLEW: begin
        // Keyboard preempts ultrasonic; the step counter keeps running.
        if (grant_q == GRANT_US && kb_req) begin
          grant_n  = GRANT_KB;
          goal_x_n = kb_x;
          goal_y_n = kb_y;
        end
        if (goal_n_reached) begin
          state_n = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (grant_q == GRANT_US && kb_req) begin
          grant_n    = GRANT_KB;
          goal_x_n   = kb_x;
          goal_y_n   = kb_y;
          settle_clr = 1'b1;
        end else if (grant_q == GRANT_KB && !kb_req && us_req) begin
          grant_n    = GRANT_US;
          goal_x_n   = us_x;
          goal_y_n   = us_y;
          settle_clr = 1'b1;
        end
        if (!goal_n_reached) begin
          state_n = ST_SLEW;
        end else if (!settle_clr && settle_last) begin
          state_n = ST_IDLE;
          grant_n = GRANT_NONE;
        end
      end

      default: begin
        state_n = ST_IDLE;
        grant_n = GRANT_NONE;
      end
    endcase
  end

  // Step counter only runs while staying in SLEW, so any entry into SLEW
  // from another state starts a fresh STEP_CYCLES interval, while a
  // preemption that stays in SLEW keeps the running count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant_q    <= GRANT_NONE;
      goal_x     <= COORD_W'(HOME_X);
      goal_y     <= COORD_W'(HOME_Y);
      step_cnt   <= '0;
      settle_cnt <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      goal_x  <= goal_x_n;
      goal_y  <= goal_y_n;
      if (state == ST_SLEW && state_n == ST_SLEW && !step_last) begin
        step_cnt <= step_cnt + 1'b1;
      end else begin
        step_cnt <= '0;
      end
      if (state == ST_SETTLE && state_n == ST_SETTLE && !settle_clr) begin
        settle_cnt <= settle_cnt + 1'b1;
      end else begin
        settle_cnt <= '0;
      end
    end
  end

  axis_slewer #(.HOME(HOME_X)) u_axis_x (
    .clk   (clk),
    .reset (reset),
    .step  (step_stb),
    .goal  (goal_x),
    .pos   (target_x)
  );

  axis_slewer #(.HOME(HOME_Y)) u_axis_y (
    .clk   (clk),
    .reset (reset),
    .step  (step_stb),
    .goal  (goal_y),
    .pos   (target_y)
  );

  assign servo_en  = (state != ST_IDLE);
  assign busy      = (state == ST_SLEW);
  assign grant     = grant_q;
  assign at_target = (target_x == goal_x) && (target_y == goal_y);

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with STEP_CYCLES=4, SETTLE_CYCLES=10,
// HOME=(2,2). Inputs change and outputs are sampled 1 time unit after a
// rising clock edge.
module tb_motion_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       kb_req = 1'b0;
  logic [7:0] kb_x = 8'd0, kb_y = 8'd0;
  logic       us_req = 1'b0;
  logic [7:0] us_x = 8'd0, us_y = 8'd0;
  logic [7:0] target_x, target_y;
  logic       servo_en, busy, at_target;
  logic [1:0] grant;

  int n_cmp = 0;
  int n_bad = 0;

  motion_sequencer #(
    .STEP_CYCLES   (4),
    .SETTLE_CYCLES (10),
    .HOME_X        (2),
    .HOME_Y        (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .kb_req    (kb_req),
    .kb_x      (kb_x),
    .kb_y      (kb_y),
    .us_req    (us_req),
    .us_x      (us_x),
    .us_y      (us_y),
    .target_x  (target_x),
    .target_y  (target_y),
    .servo_en  (servo_en),
    .grant     (grant),
    .busy      (busy),
    .at_target (at_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Asynchronous reset, sampled before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_tx", target_x, 2);
    check("rst_ty", target_y, 2);
    check("rst_servo", servo_en, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_at", at_target, 1);
    reset = 1'b0;
    tick(1);

    // Keyboard move (2,2) -> (5,3)
    kb_x = 8'd5; kb_y = 8'd3; kb_req = 1'b1;
    tick(1);
    check("kb_grant", grant, 1);
    check("kb_busy", busy, 1);
    check("kb_at0", at_target, 0);
    kb_req = 1'b0;
    tick(3);
    check("kb_nostep_x", target_x, 2);
    tick(1);
    check("kb_s1_x", target_x, 3);
    check("kb_s1_y", target_y, 3);
    tick(4);
    check("kb_s2_x", target_x, 4);
    tick(4);
    check("kb_s3_x", target_x, 5);
    check("kb_s3_y", target_y, 3);
    check("kb_s3_busy", busy, 1);
    tick(1);
    check("kb_settle_busy", busy, 0);
    check("kb_settle_en", servo_en, 1);
    tick(9);
    check("kb_settle_end_en", servo_en, 1);
    tick(1);
    check("kb_idle_en", servo_en, 0);
    check("kb_idle_grant", grant, 0);
    tick(5);
    check("idle_hold_x", target_x, 5);
    check("idle_hold_y", target_y, 3);

    // Simultaneous requests: keyboard wins, descends to (0,0) without wrap
    pulse_reset();
    tick(1);
    check("both_rst_x", target_x, 2);
    kb_x = 8'd0; kb_y = 8'd0; us_x = 8'd9; us_y = 8'd9;
    kb_req = 1'b1; us_req = 1'b1;
    tick(1);
    check("both_grant", grant, 1);
    tick(4);
    check("both_s1_x", target_x, 1);
    check("both_s1_y", target_y, 1);
    tick(4);
    check("both_s2_x", target_x, 0);
    check("both_s2_y", target_y, 0);
    tick(4);
    check("both_hold_x", target_x, 0);
    check("both_hold_grant", grant, 1);
    kb_req = 1'b0; us_req = 1'b0;
    tick(20);
    check("both_idle_en", servo_en, 0);
    check("both_idle_x", target_x, 0);

    // Full-range climb (0,0) -> (255,255)
    kb_x = 8'd255; kb_y = 8'd255; kb_req = 1'b1;
    tick(1);
    kb_req = 1'b0;
    tick(4 * 254);
    check("full_254_x", target_x, 254);
    tick(4);
    check("full_255_x", target_x, 255);
    check("full_255_y", target_y, 255);
    check("full_busy", busy, 1);
    tick(1);
    check("full_settle_busy", busy, 0);
    tick(8);
    check("full_hold_x", target_x, 255);
    check("full_hold_y", target_y, 255);
    tick(10);
    check("full_idle_en", servo_en, 0);

    // Ultrasonic toward (8,2) preempted by keyboard (2,6)
    pulse_reset();
    tick(1);
    us_x = 8'd8; us_y = 8'd2; us_req = 1'b1;
    tick(1);
    check("pre_us_grant", grant, 2);
    tick(4);
    check("pre_us_s1_x", target_x, 3);
    tick(4);
    check("pre_us_s2_x", target_x, 4);
    tick(1);
    kb_x = 8'd2; kb_y = 8'd6; kb_req = 1'b1;
    tick(1);
    check("pre_kb_grant", grant, 1);
    tick(1);
    check("pre_hold_x", target_x, 4);
    tick(1);
    check("pre_rev_x", target_x, 3);
    check("pre_rev_y", target_y, 3);
    us_req = 1'b0;
    tick(4);
    check("pre_s2_x", target_x, 2);
    check("pre_s2_y", target_y, 4);
    check("pre_keep_grant", grant, 1);
    kb_req = 1'b0;

    // Reset mid-slew at (4,4)
    pulse_reset();
    tick(1);
    kb_x = 8'd6; kb_y = 8'd6; kb_req = 1'b1;
    tick(9);
    check("mid_at4_x", target_x, 4);
    check("mid_at4_y", target_y, 4);
    reset = 1'b1;
    #1;
    check("mid_rst_x", target_x, 2);
    check("mid_rst_y", target_y, 2);
    check("mid_rst_en", servo_en, 0);
    check("mid_rst_grant", grant, 0);
    kb_req = 1'b0;
    #1 reset = 1'b0;
    tick(10);
    check("mid_after_x", target_x, 2);
    check("mid_after_en", servo_en, 0);
    check("mid_after_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
